slt_iter_cmp: RTL and testbench
===============================

Name: slt_iter_cmp

Overview:
Parametrised, iterative set-on-compare unit for the ALU/EX path. It supports unsigned less-than, signed less-than, equal and not-equal. It compares CHUNK bits per cycle, starting from the MSB chunk, and exits early at the first differing chunk. The result is WIDTH bits, zero-extended 0/1, and is returned through a start/busy/done handshake so the pipeline can stall on it.

Parameters:
WIDTH, 32, operand and result width in bits
CHUNK, 8, bits compared per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails
NUM_CHUNKS, WIDTH/CHUNK, derived localparam, not overridable

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only when state is IDLE or DONE
op  in  2  operation: 00 SLTU, 01 SLT, 10 SEQ, 11 SNE
a  in  WIDTH  operand A; captured on accepted start
b  in  WIDTH  operand B; captured on accepted start
flush  in  1  synchronous abort, e.g. pipeline flush
busy  out  1  high while state is CMP
done  out  1  one-cycle pulse; res is valid from this cycle
res  out  WIDTH  {WIDTH-1 zeros, flag}; held until the next done

Behaviour:
- Reset (rst_n low, async): state=IDLE, idx=0, busy=0, done=0, res=0, captured operands cleared. Takes effect immediately, including mid-operation.
- States: IDLE, CMP, DONE.
  - IDLE/DONE with start=1 and flush=0: capture a, b, op; idx=0; go to CMP.
  - DONE with start=0: go to IDLE.
  - Start while in CMP is ignored; the requester must hold or retry.
- CMP, one chunk per cycle (chunk idx = bits [WIDTH-1-idx*CHUNK -: CHUNK]):
  - SLT: the sign bit of both captured operands is inverted before the chunk 0 compare. This biases the operands so the unsigned chunk compare gives the signed result. Other chunks are compared unsigned.
  - If chunkA != chunkB: the result is decided. SLTU/SLT flag = (chunkA < chunkB); SEQ flag = 0; SNE flag = 1. Go to DONE.
  - If the chunks are equal and idx = NUM_CHUNKS-1: SLTU/SLT flag = 0; SEQ flag = 1; SNE flag = 0. Go to DONE.
  - Otherwise: idx+1, stay in CMP.
- res is registered on the same edge that enters DONE. done = (state==DONE), exactly one cycle per operation.
- Latency: if the start is accepted at edge E0 and k is the first differing chunk index (k = NUM_CHUNKS-1 if all chunks are equal), done is high in the cycle after edge E(k+1).
  - Minimum latency is 1 cycle; maximum is NUM_CHUNKS cycles.
  - busy is high for k+1 cycles.
- Back-to-back: start accepted in DONE goes directly to CMP, so throughput is one operation per (k+2) cycles.
- flush=1 (synchronous, highest priority after reset):
  - Next state is IDLE, busy drops next cycle, no done is produced, res retains its old value.
  - flush with start in the same cycle: flush wins and start is dropped.
- WIDTH == CHUNK degenerates to a fixed 1-cycle compare, with the same handshake.
- idx width is max(1, clog2(NUM_CHUNKS)). idx never exceeds NUM_CHUNKS-1.

Decomposition:
- Shared package/header: op encodings (OP_SLTU=2'b00, OP_SLT=2'b01, OP_SEQ=2'b10, OP_SNE=2'b11) and state encodings, so the decoder and ALU use the same constants.
- One combinational sub-module, slt_chunk_cmp (CHUNK-wide inputs; outputs lt and ne), instantiated once and muxed by idx.
- FSM, idx counter, operand registers and result register live in slt_iter_cmp.

Test Plan:
- Test 1: WIDTH=32, CHUNK=8. SLTU a=0x00000001, b=0xFFFFFFFF. Expect done 1 cycle after start, res=0x00000001, busy high 1 cycle.
- Test 2: SLT a=0x00000001, b=0xFFFFFFFF. Expect res=0x00000000 at 1 cycle.
- Test 3: SLT a=0x80000000, b=0x7FFFFFFF. Expect res=0x00000001 at 1 cycle.
- Test 4: SEQ a=b=0x12345678. Expect done at 4 cycles, res=1, busy high 4 cycles. Then SNE with the same operands gives res=0.
- Test 5: SLTU a=0x12345677, b=0x12345678. Expect done at 4 cycles, res=1. Then start held high in the DONE cycle with SLTU a=0xFF000000, b=0x01000000 (back-to-back). Expect second done 1 cycle later, res=0.
- Test 6: start SEQ a=b=0xAAAAAAAA, pulse flush in the 2nd busy cycle. Expect no done, busy=0 next cycle, res unchanged. Repeat with rst_n pulled low mid-CMP. Expect busy/done/res=0 asynchronously, then a clean operation after release.

Source files
------------

// File: rtl/slt_iter_cmp_pkg.sv
// Shared constants for the iterative set-on-compare unit: operation and FSM state encodings.
package slt_iter_cmp_pkg;

   typedef enum logic [1:0] {
      OP_SLTU = 2'b00,
      OP_SLT  = 2'b01,
      OP_SEQ  = 2'b10,
      OP_SNE  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CMP  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage : slt_iter_cmp_pkg

// File: rtl/slt_iter_cmp_if.sv
// Request/response bundle between the EX stage (master) and the compare unit (slave).
interface slt_iter_cmp_if
   import slt_iter_cmp_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic             start;
   op_e              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] res;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, res
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, res
   );

endinterface : slt_iter_cmp_if

// File: rtl/slt_iter_cmp_chunk_cmp.sv
// One chunk of the iterative compare: unsigned less-than and inequality of two CHUNK-bit slices.
module slt_chunk_cmp #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   output logic             o_lt,
   output logic             o_ne
);

   assign o_lt = (i_a < i_b);
   assign o_ne = (i_a != i_b);

endmodule : slt_chunk_cmp

// File: rtl/slt_iter_cmp.sv
// Iterative SLTU/SLT/SEQ/SNE unit: walks CHUNK-bit slices from the MSB end, stopping at the
// first difference, and returns a zero-extended flag through a start/busy/done handshake.
module slt_iter_cmp
   import slt_iter_cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   slt_iter_cmp_if.slave io_cmp
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("slt_iter_cmp: WIDTH must be a multiple of CHUNK");
   end

   state_e             r_state;
   state_e             w_state_nx;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nx;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   op_e                r_op;
   logic               r_flag;
   logic               w_flag_nx;
   logic               w_cap;
   logic               w_last;
   logic [WIDTH-1:0]   w_bias;
   logic [CHUNK-1:0]   w_chunk_a;
   logic [CHUNK-1:0]   w_chunk_b;
   logic               w_lt;
   logic               w_ne;

   // Flipping both sign bits at capture turns the signed compare into an unsigned one.
   assign w_bias = (io_cmp.op == OP_SLT) ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};
   assign w_last = (r_idx == IDX_W'(NUM_CHUNKS - 1));

   if (NUM_CHUNKS == 1) begin : g_single
      assign w_chunk_a = r_a;
      assign w_chunk_b = r_b;
   end else begin : g_multi
      logic [CHUNK-1:0] w_ca [NUM_CHUNKS];
      logic [CHUNK-1:0] w_cb [NUM_CHUNKS];
      for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_slice
         assign w_ca[gi] = r_a[WIDTH-1-gi*CHUNK -: CHUNK];
         assign w_cb[gi] = r_b[WIDTH-1-gi*CHUNK -: CHUNK];
      end
      assign w_chunk_a = w_ca[r_idx];
      assign w_chunk_b = w_cb[r_idx];
   end

   slt_chunk_cmp #(
      .CHUNK (CHUNK)
   ) u_chunk_cmp (
      .i_a  (w_chunk_a),
      .i_b  (w_chunk_b),
      .o_lt (w_lt),
      .o_ne (w_ne)
   );

   // Next-state, chunk index and result flag decision.
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_flag_nx  = r_flag;
      w_cap      = 1'b0;
      if (io_cmp.flush) begin
         w_state_nx = ST_IDLE;
         w_idx_nx   = {IDX_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (io_cmp.start) begin
                  w_state_nx = ST_CMP;
                  w_idx_nx   = {IDX_W{1'b0}};
                  w_cap      = 1'b1;
               end else begin
                  w_state_nx = ST_IDLE;
               end
            end
            ST_CMP: begin
               if (w_ne) begin
                  w_flag_nx  = r_op[1] ? (r_op == OP_SNE) : w_lt;
                  w_state_nx = ST_DONE;
               end else if (w_last) begin
                  w_flag_nx  = (r_op == OP_SEQ);
                  w_state_nx = ST_DONE;
               end else begin
                  w_idx_nx   = r_idx + IDX_W'(1);
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
               w_idx_nx   = {IDX_W{1'b0}};
            end
         endcase
      end
   end

   // State, index and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= {IDX_W{1'b0}};
         r_flag  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_flag  <= w_flag_nx;
      end
   end

   // Operand capture on an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a  <= {WIDTH{1'b0}};
         r_b  <= {WIDTH{1'b0}};
         r_op <= OP_SLTU;
      end else if (w_cap) begin
         r_a  <= io_cmp.a ^ w_bias;
         r_b  <= io_cmp.b ^ w_bias;
         r_op <= io_cmp.op;
      end else begin
         r_a  <= r_a;
         r_b  <= r_b;
         r_op <= r_op;
      end
   end

   assign io_cmp.busy = (r_state == ST_CMP);
   assign io_cmp.done = (r_state == ST_DONE);
   assign io_cmp.res  = {{(WIDTH-1){1'b0}}, r_flag};

endmodule : slt_iter_cmp

// File: tb/tb_slt_iter_cmp.sv
// Directed bench for slt_iter_cmp (WIDTH=32, CHUNK=8): vector table plus flush/reset/back-to-back sequences.
module tb_slt_iter_cmp;
   import slt_iter_cmp_pkg::*;

   localparam int W = 32;

   typedef struct {
      op_e         op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   slt_iter_cmp_if #(.WIDTH(W)) u_if ();

   slt_iter_cmp #(
      .WIDTH (W),
      .CHUNK (8)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_cmp (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for done; busy cycles and latency are counted.
   task automatic do_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output logic [31:0] res);
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.op    = op;
      u_if.a     = a;
      u_if.b     = b;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      lat        = 0;
      busy_cnt   = 0;
      while (u_if.done !== 1'b1 && lat < 20) begin
         if (u_if.busy === 1'b1) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      res = u_if.res;
   endtask

   vec_t        vecs [13];
   int          lat;
   int          bcnt;
   logic [31:0] res;
   logic [31:0] res_before;
   int          seen_done;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      vecs[0]  = '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1, 1};
      vecs[1]  = '{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1};
      vecs[2]  = '{OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1};
      vecs[3]  = '{OP_SEQ,  32'h1234_5678, 32'h1234_5678, 32'h1, 4};
      vecs[4]  = '{OP_SNE,  32'h1234_5678, 32'h1234_5678, 32'h0, 4};
      vecs[5]  = '{OP_SLTU, 32'h1234_5677, 32'h1234_5678, 32'h1, 4};
      vecs[6]  = '{OP_SLTU, 32'hFF00_0000, 32'h0100_0000, 32'h0, 1};
      vecs[7]  = '{OP_SEQ,  32'h1234_5678, 32'h1234_0000, 32'h0, 3};
      vecs[8]  = '{OP_SNE,  32'h1234_5678, 32'h12FF_5678, 32'h1, 2};
      vecs[9]  = '{OP_SLT,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1, 4};
      vecs[10] = '{OP_SLTU, 32'h0000_0000, 32'h0000_0000, 32'h0, 4};
      vecs[11] = '{OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1};
      vecs[12] = '{OP_SLT,  32'h0000_0005, 32'h0000_0100, 32'h1, 3};

      u_if.start = 1'b0;
      u_if.op    = OP_SLTU;
      u_if.a     = 32'h0;
      u_if.b     = 32'h0;
      u_if.flush = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'h0, u_if.busy}, 32'h0);
      chk("reset_done", {31'h0, u_if.done}, 32'h0);
      chk("reset_res", u_if.res, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, res);
         chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].exp_lat));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_done_pulse", i), {31'h0, u_if.done}, 32'h0);
         chk($sformatf("vec%0d_res_hold", i), u_if.res, vecs[i].exp_res);
      end

      // Back-to-back: second start held during the DONE cycle.
      do_op(OP_SLTU, 32'h1234_5677, 32'h1234_5678, lat, bcnt, res);
      chk("b2b_first_res", res, 32'h1);
      chk("b2b_first_lat", 32'(lat), 32'd4);
      u_if.start = 1'b1;
      u_if.op    = OP_SLTU;
      u_if.a     = 32'hFF00_0000;
      u_if.b     = 32'h0100_0000;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      chk("b2b_busy", {31'h0, u_if.busy}, 32'h1);
      chk("b2b_no_done", {31'h0, u_if.done}, 32'h0);
      @(posedge clk);
      #1;
      chk("b2b_second_done", {31'h0, u_if.done}, 32'h1);
      chk("b2b_second_res", u_if.res, 32'h0);

      // Flush in the second busy cycle: no done, busy drops, result kept.
      res_before = u_if.res;
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.op    = OP_SEQ;
      u_if.a     = 32'hAAAA_AAAA;
      u_if.b     = 32'hAAAA_AAAA;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      @(posedge clk);
      #1;
      chk("flush_pre_busy", {31'h0, u_if.busy}, 32'h1);
      u_if.flush = 1'b1;
      @(posedge clk);
      #1;
      u_if.flush = 1'b0;
      chk("flush_busy", {31'h0, u_if.busy}, 32'h0);
      seen_done = 0;
      for (int c = 0; c < 6; c++) begin
         if (u_if.done === 1'b1) seen_done++;
         @(posedge clk);
         #1;
      end
      chk("flush_no_done", 32'(seen_done), 32'd0);
      chk("flush_res_kept", u_if.res, res_before);

      // Flush and start together: start is dropped.
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.flush = 1'b1;
      u_if.op    = OP_SNE;
      u_if.a     = 32'h1;
      u_if.b     = 32'h2;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      u_if.flush = 1'b0;
      chk("flush_start_busy", {31'h0, u_if.busy}, 32'h0);
      @(posedge clk);
      #1;
      chk("flush_start_done", {31'h0, u_if.done}, 32'h0);

      // Asynchronous reset mid-CMP with a nonzero result held.
      do_op(OP_SEQ, 32'hAAAA_AAAA, 32'hAAAA_AAAA, lat, bcnt, res);
      chk("pre_rst_res", res, 32'h1);
      @(negedge clk);
      u_if.start = 1'b1;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'h0, u_if.busy}, 32'h0);
      chk("arst_done", {31'h0, u_if.done}, 32'h0);
      chk("arst_res", u_if.res, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(OP_SLTU, 32'h0000_0001, 32'h0000_0002, lat, bcnt, res);
      chk("post_rst_res", res, 32'h1);
      chk("post_rst_lat", 32'(lat), 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_slt_iter_cmp
